// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID instruction queue.
// master: the fetch/decode side driving the queue; slave: the queue itself.
interface if_id_queue_if #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned INSTR_W = 32
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  // Fetch side
  logic               enq_valid_F;
  logic               enq_ready_F;
  logic [ADDR_W-1:0]  pc_F;
  logic [INSTR_W-1:0] instr_F;

  // Decode side
  logic               flush_D;
  logic               deq_valid_D;
  logic               deq_ready_D;
  logic [ADDR_W-1:0]  pc_D;
  logic [INSTR_W-1:0] instr_D;

  // Occupancy
  logic [CntW-1:0]    count;

  modport master (
    output enq_valid_F,
    output pc_F,
    output instr_F,
    output flush_D,
    output deq_ready_D,
    input  enq_ready_F,
    input  deq_valid_D,
    input  pc_D,
    input  instr_D,
    input  count
  );

  modport slave (
    input  enq_valid_F,
    input  pc_F,
    input  instr_F,
    input  flush_D,
    input  deq_ready_D,
    output enq_ready_F,
    output deq_valid_D,
    output pc_D,
    output instr_D,
    output count
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: circular buffer of {pc, instr} pairs between fetch
// and decode, show-ahead head outputs, whole-queue flush on a taken branch.
// Optional macro IF_ID_QUEUE_BYPASS_EN forwards fetch straight to decode when
// the queue is empty (zero-latency path).
module if_id_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned INSTR_W = 32
) (
  input  logic          clk,
  input  logic          reset,
  if_id_queue_if.slave  bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Storage
  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];

  // Pointers and occupancy
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic is_full;
  logic is_empty;
  logic enq_ready;
  logic deq_valid;
  logic enq_fire;
  logic deq_fire;
  logic bypass;       // empty queue forwarding the incoming fetch entry
  logic bypass_take;  // forwarded entry consumed, never stored
  logic do_write;
  logic do_read;

  assign is_full   = (count_q == CntW'(DEPTH));
  assign is_empty  = (count_q == '0);
  // Ready depends only on occupancy so fetch never sees a path from decode.
  assign enq_ready = !is_full;

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign bypass      = is_empty && bus.enq_valid_F && !bus.flush_D;
  assign bypass_take = bypass && bus.deq_ready_D;
`else
  assign bypass      = 1'b0;
  assign bypass_take = 1'b0;
`endif

  assign deq_valid = !is_empty || bypass;
  assign enq_fire  = bus.enq_valid_F && enq_ready && !bus.flush_D;
  assign deq_fire  = deq_valid && bus.deq_ready_D && !bus.flush_D;
  assign do_write  = enq_fire && !bypass_take;
  assign do_read   = deq_fire && !bypass_take;

  // Next-state for pointers and count; flush overrides any handshake.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush_D) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_write) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (do_read) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({do_write, do_read})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so nothing from before reset can resurface.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (do_write) begin
      pc_mem_q[wr_ptr_q]    <= bus.pc_F;
      instr_mem_q[wr_ptr_q] <= bus.instr_F;
    end
  end

  // Show-ahead head outputs, forced to zero when nothing is valid.
  always_comb begin
    bus.pc_D    = '0;
    bus.instr_D = '0;
    if (bypass) begin
      bus.pc_D    = bus.pc_F;
      bus.instr_D = bus.instr_F;
    end else if (!is_empty) begin
      bus.pc_D    = pc_mem_q[rd_ptr_q];
      bus.instr_D = instr_mem_q[rd_ptr_q];
    end
  end

  assign bus.enq_ready_F = enq_ready;
  assign bus.deq_valid_D = deq_valid;
  assign bus.count       = count_q;

endmodule
